// File: rtl/buffer_arbiter_pkg.sv
// Shared types and sizing for the USB packet buffer arbiter.
// The state encoding is visible to software through the status register.
package usb_buffer_pkg;

    localparam int BUFFER_DEPTH = 64;
    localparam int OCC_WIDTH    = 7;

    localparam logic [OCC_WIDTH-1:0] OCC_EMPTY = {OCC_WIDTH{1'b0}};
    localparam logic [OCC_WIDTH-1:0] OCC_FULL  = OCC_WIDTH'(BUFFER_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TX_FILL  = 3'd1,
        ST_TX_READY = 3'd2,
        ST_TX_SEND  = 3'd3,
        ST_RX_FILL  = 3'd4,
        ST_RX_DRAIN = 3'd5
    } buf_state_e;

endpackage

// File: rtl/buffer_arbiter_if.sv
// Request, strobe and status bundle between the AHB/USB engines and the buffer arbiter.
// The master side drives the requests and occupancy; the slave side is the arbiter.
interface buffer_arbiter_if;
    import usb_buffer_pkg::*;

    logic                 ahbTxReq;
    logic [OCC_WIDTH-1:0] txPacketDataSize;
    logic                 ahbStore;
    logic                 ahbGet;
    logic                 ahbClear;
    logic                 usbRxReq;
    logic                 usbRxDone;
    logic                 usbRxError;
    logic                 usbTxReq;
    logic                 usbStore;
    logic                 usbGet;
    logic [OCC_WIDTH-1:0] bufferOccupancy;
    logic                 bufferStore;
    logic                 bufferGet;
    logic                 bufferClear;
    logic                 storeFromUsb;
    logic                 bufferReserved;
    logic                 rxDataReady;
    logic                 txDone;
    logic                 txNak;
    logic                 rxNak;
    logic                 ahbError;
    logic [2:0]           state;

    modport master (
        output ahbTxReq, txPacketDataSize, ahbStore, ahbGet, ahbClear,
        output usbRxReq, usbRxDone, usbRxError, usbTxReq, usbStore, usbGet,
        output bufferOccupancy,
        input  bufferStore, bufferGet, bufferClear, storeFromUsb, bufferReserved,
        input  rxDataReady, txDone, txNak, rxNak, ahbError, state
    );

    modport slave (
        input  ahbTxReq, txPacketDataSize, ahbStore, ahbGet, ahbClear,
        input  usbRxReq, usbRxDone, usbRxError, usbTxReq, usbStore, usbGet,
        input  bufferOccupancy,
        output bufferStore, bufferGet, bufferClear, storeFromUsb, bufferReserved,
        output rxDataReady, txDone, txNak, rxNak, ahbError, state
    );

endinterface

// File: rtl/buffer_arbiter.sv
// Ownership sequencer for the shared 64-byte packet buffer: one owner at a time,
// gated FIFO strobes, flush handling and registered NAK/done/error events.
module buffer_arbiter
    import usb_buffer_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    buffer_arbiter_if.slave bus
);

    buf_state_e           state_r, state_nxt_s;
    logic [OCC_WIDTH-1:0] size_r, size_nxt_s;
    logic                 store_s, get_s, clear_s;
    logic                 tx_done_s, tx_nak_s, contention_s;
    logic                 rx_nak_s, ahb_error_s;
    logic                 tx_done_r, tx_nak_r, rx_nak_r, ahb_error_r;
    logic                 occ_empty_s, occ_full_s, occ_at_size_s, tx_room_s;

    // Occupancy is the FIFO's post-update count, so exits happen the cycle after the last strobe.
    assign occ_empty_s   = (bus.bufferOccupancy == OCC_EMPTY);
    assign occ_full_s    = (bus.bufferOccupancy >= OCC_FULL);
    assign occ_at_size_s = (bus.bufferOccupancy == size_r);
    assign tx_room_s     = ~occ_at_size_s & ~occ_full_s;

    assign rx_nak_s    = bus.usbRxReq & ((state_r == ST_TX_FILL) | (state_r == ST_TX_READY) |
                                         (state_r == ST_TX_SEND) | (state_r == ST_RX_DRAIN));
    assign ahb_error_s = contention_s
                       | (bus.ahbStore & ~((state_r == ST_TX_FILL) & tx_room_s))
                       | (bus.ahbGet & (state_r != ST_RX_DRAIN));

    // Next-state, size latch and same-cycle strobe gating.
    always_comb begin
        state_nxt_s  = state_r;
        size_nxt_s   = size_r;
        store_s      = 1'b0;
        get_s        = 1'b0;
        clear_s      = 1'b0;
        tx_done_s    = 1'b0;
        tx_nak_s     = 1'b0;
        contention_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.ahbClear) begin
                    clear_s    = 1'b1;
                    size_nxt_s = OCC_EMPTY;
                end else if (bus.usbRxReq) begin
                    state_nxt_s  = ST_RX_FILL;
                    contention_s = bus.ahbTxReq;
                end else if (bus.ahbTxReq) begin
                    size_nxt_s  = bus.txPacketDataSize;
                    state_nxt_s = (bus.txPacketDataSize == OCC_EMPTY) ? ST_TX_READY : ST_TX_FILL;
                end else begin
                    tx_nak_s = bus.usbTxReq;
                end
            end
            ST_TX_FILL: begin
                store_s = bus.ahbStore & tx_room_s;
                if (bus.ahbClear) begin
                    clear_s     = 1'b1;
                    size_nxt_s  = OCC_EMPTY;
                    state_nxt_s = ST_IDLE;
                end else if (occ_at_size_s) begin
                    state_nxt_s = ST_TX_READY;
                end else begin
                    state_nxt_s = ST_TX_FILL;
                end
            end
            ST_TX_READY: begin
                if (bus.ahbClear) begin
                    clear_s     = 1'b1;
                    size_nxt_s  = OCC_EMPTY;
                    state_nxt_s = ST_IDLE;
                end else if (bus.usbTxReq) begin
                    state_nxt_s = ST_TX_SEND;
                end else begin
                    state_nxt_s = ST_TX_READY;
                end
            end
            ST_TX_SEND: begin
                get_s = bus.usbGet & ~occ_empty_s;
                if (occ_empty_s) begin
                    state_nxt_s = ST_IDLE;
                    tx_done_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_TX_SEND;
                end
            end
            ST_RX_FILL: begin
                store_s = bus.usbStore & ~occ_full_s;
                if (bus.usbRxError) begin
                    clear_s     = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else if (bus.usbRxDone) begin
                    state_nxt_s = ST_RX_DRAIN;
                end else begin
                    state_nxt_s = ST_RX_FILL;
                end
            end
            ST_RX_DRAIN: begin
                get_s = bus.ahbGet & ~occ_empty_s;
                if (bus.ahbClear) begin
                    clear_s     = 1'b1;
                    size_nxt_s  = OCC_EMPTY;
                    state_nxt_s = ST_IDLE;
                end else if (occ_empty_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RX_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, size latch and one-cycle event pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            size_r      <= OCC_EMPTY;
            tx_done_r   <= 1'b0;
            tx_nak_r    <= 1'b0;
            rx_nak_r    <= 1'b0;
            ahb_error_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            size_r      <= size_nxt_s;
            tx_done_r   <= tx_done_s;
            tx_nak_r    <= tx_nak_s;
            rx_nak_r    <= rx_nak_s;
            ahb_error_r <= ahb_error_s;
        end
    end

    // FIFO controls are suppressed during reset so an abandoned packet never pulses the FIFO.
    assign bus.bufferStore    = store_s & ~rst;
    assign bus.bufferGet      = get_s & ~rst;
    assign bus.bufferClear    = clear_s & ~rst;
    assign bus.storeFromUsb   = (state_r == ST_RX_FILL);
    assign bus.bufferReserved = (state_r != ST_IDLE);
    assign bus.rxDataReady    = (state_r == ST_RX_DRAIN);
    assign bus.state          = state_r;
    assign bus.txDone         = tx_done_r;
    assign bus.txNak          = tx_nak_r;
    assign bus.rxNak          = rx_nak_r;
    assign bus.ahbError       = ahb_error_r;

endmodule
